// File: rtl/dac_conditioner.sv
// Two-stage DAC conditioner: round/shift, offset and clip, then peak hold over WINDOW samples.
// Optional DAC_SAT_COUNTER_EN adds sat_clr/sat_count, a saturating count of clipped samples.
module dac_conditioner #(
    parameter int BITS_IN  = 50,
    parameter int BITS_OUT = 14,
    parameter int SHIFT    = 16,
    parameter int OFFSET   = 8192,
    parameter int WINDOW   = 1024
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [BITS_IN-1:0]  in,
`ifdef DAC_SAT_COUNTER_EN
    input  logic                sat_clr,
    output logic [15:0]         sat_count,
`endif
    output logic [BITS_OUT-1:0] dac_out,
    output logic                out_valid,
    output logic                sat_flag,
    output logic [BITS_OUT-1:0] peak,
    output logic                peak_valid
);

    localparam int CW = $clog2(WINDOW);
    localparam logic signed [BITS_IN:0]   RND     = (BITS_IN+1)'(64'd1 << (SHIFT-1));
    localparam logic signed [BITS_IN+1:0] OFF_EXT = (BITS_IN+2)'(OFFSET);
    localparam logic signed [BITS_IN+1:0] MAX_EXT = (BITS_IN+2)'((64'd1 << BITS_OUT) - 64'd1);
    localparam logic [CW-1:0]             LAST    = CW'(WINDOW-1);

    // vld_pipe[1] is v1 (stage 1), vld_pipe[2] is out_valid
    logic [2:1]                vld_pipe;
    logic signed [BITS_IN:0]   s1;
    logic signed [BITS_IN:0]   rnd_sum;
    logic signed [BITS_IN+1:0] t;
    logic                      clip_lo, clip_hi;
    logic [BITS_OUT-1:0]       code;
    logic [CW-1:0]             cnt;
    logic [BITS_OUT-1:0]       run_max;
    logic [BITS_OUT-1:0]       win_max;

    assign out_valid = vld_pipe[2];

    // One extra bit so the rounding add cannot wrap for inputs near the positive limit
    always_comb begin
        rnd_sum = $signed({in[BITS_IN-1], in}) + RND;
        t       = $signed({s1[BITS_IN], s1}) + OFF_EXT;
        clip_lo = t[BITS_IN+1];
        clip_hi = !clip_lo && (t > MAX_EXT);
        code    = t[BITS_OUT-1:0];
        if (clip_lo)
            code = '0;
        else if (clip_hi)
            code = '1;
        win_max = (dac_out > run_max) ? dac_out : run_max;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            s1       <= '0;
            dac_out  <= BITS_OUT'(OFFSET);
            sat_flag <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], in_valid};
            s1       <= rnd_sum >>> SHIFT;
            if (vld_pipe[1]) begin
                dac_out  <= code;
                sat_flag <= clip_lo | clip_hi;
            end
        end
    end

    // Peak hold: the running max restarts empty after each completed window
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            run_max    <= '0;
            peak       <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (out_valid) begin
                if (cnt == LAST) begin
                    peak       <= win_max;
                    peak_valid <= 1'b1;
                    cnt        <= '0;
                    run_max    <= '0;
                end else begin
                    cnt     <= cnt + CW'(1);
                    run_max <= win_max;
                end
            end
        end
    end

`ifdef DAC_SAT_COUNTER_EN
    // Counted at the edge that loads the clipped code, so it tracks sat_flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            sat_count <= '0;
        else if (sat_clr)
            sat_count <= '0;
        else if (vld_pipe[1] && (clip_lo || clip_hi) && (sat_count != 16'hFFFF))
            sat_count <= sat_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dac_conditioner.sv
// Bench for dac_conditioner (WINDOW=4): directed checks plus randomized traffic against a list-based model.
module tb_dac_conditioner;
    localparam int BITS_IN  = 50;
    localparam int BITS_OUT = 14;
    localparam int SHIFT    = 16;
    localparam int OFFSET   = 8192;
    localparam int WINDOW   = 4;
    localparam longint CMAX = (64'sd1 << BITS_OUT) - 1;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                in_valid;
    logic [BITS_IN-1:0]  in;
    logic [BITS_OUT-1:0] dac_out;
    logic                out_valid;
    logic                sat_flag;
    logic [BITS_OUT-1:0] peak;
    logic                peak_valid;
`ifdef DAC_SAT_COUNTER_EN
    logic                sat_clr;
    logic [15:0]         sat_count;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_on = 0;

    dac_conditioner #(.BITS_IN(BITS_IN), .BITS_OUT(BITS_OUT), .SHIFT(SHIFT),
                      .OFFSET(OFFSET), .WINDOW(WINDOW)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in(in),
`ifdef DAC_SAT_COUNTER_EN
        .sat_clr(sat_clr), .sat_count(sat_count),
`endif
        .dac_out(dac_out), .out_valid(out_valid), .sat_flag(sat_flag),
        .peak(peak), .peak_valid(peak_valid));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected DAC code: round-to-nearest of x / 2^SHIFT, plus offset, clamped to the code range
    function automatic longint code_of(input longint x, output bit sat);
        longint q, t;
        q = (x + (64'sd1 <<< (SHIFT-1))) >>> SHIFT;
        t = q + OFFSET;
        sat = (t < 0) || (t > CMAX);
        if (t < 0) t = 0;
        if (t > CMAX) t = CMAX;
        return t;
    endfunction

    function automatic longint code(input longint x);
        bit s;
        return code_of(x, s);
    endfunction

    // Behavioural model: each output is the sample presented one edge earlier and
    // already in flight; peaks come from plain lists of emitted codes.
    typedef struct { bit v; longint x; } smp_t;
    smp_t   pend[$];
    longint win[$];
    bit     m_ov, m_sat, m_pv;
    longint m_code, m_peak;
    int     m_scnt;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend.delete(); win.delete();
            m_ov = 0; m_sat = 0; m_pv = 0; m_code = OFFSET; m_peak = 0; m_scnt = 0;
        end else begin
            smp_t s;
            bit   sat;
            longint c;
            m_pv = 0;
            if (m_ov) begin
                win.push_back(m_code);
                if (win.size() == WINDOW) begin
                    m_peak = 0;
                    foreach (win[i]) if (win[i] > m_peak) m_peak = win[i];
                    m_pv = 1;
                    win.delete();
                end
            end
            m_ov = 0;
            sat  = 0;
            if (pend.size() > 0) begin
                s = pend.pop_front();
                if (s.v) begin
                    c = code_of(s.x, sat);
                    m_ov = 1; m_code = c; m_sat = sat;
                end
            end
`ifdef DAC_SAT_COUNTER_EN
            if (sat_clr) m_scnt = 0;
            else if (m_ov && sat && m_scnt < 65535) m_scnt++;
`endif
            s.v = in_valid;
            s.x = longint'($signed(in));
            pend.push_back(s);
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("out_valid", out_valid, m_ov);
            chk("dac_out", dac_out, m_code);
            chk("sat_flag", sat_flag, m_sat);
            chk("peak", peak, m_peak);
            chk("peak_valid", peak_valid, m_pv);
`ifdef DAC_SAT_COUNTER_EN
            chk("sat_count", sat_count, m_scnt);
`endif
        end
    end

    task automatic drive(input bit v, input longint x);
        in_valid = v;
        in = BITS_IN'(x);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dac"}, dac_out, OFFSET);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_sat"}, sat_flag, 0);
        chk({tag, "_peak"}, peak, 0);
        chk({tag, "_pv"}, peak_valid, 0);
`ifdef DAC_SAT_COUNTER_EN
        chk({tag, "_scnt"}, sat_count, 0);
`endif
    endtask

    task automatic pulse_reset();
        reset_n = 0;
        #1;
        chk_reset_vals("midreset");
        @(posedge clock);
        #1;
        reset_n = 1;
    endtask

    longint rv[4];
    longint bv[5];
    bit     bp[5];
    bit     obs[7];

    initial begin
        reset_n = 0; in_valid = 0; in = '0;
`ifdef DAC_SAT_COUNTER_EN
        sat_clr = 0;
`endif
        // Pin the model against hand-computed codes
        chk("model_round_a", code(6553600), 8292);
        chk("model_round_b", code(32768), 8193);
        chk("model_round_c", code(-32768), 8192);
        chk("model_round_d", code(-32769), 8191);
        chk("model_sat_hi", code(9000 * 65536), 16383);
        chk("model_sat_lo", code(-9000 * 65536), 0);

        repeat (3) @(posedge clock);
        #1;
        chk_reset_vals("reset");
        chk_on = 1;
        reset_n = 1;
        drive(0, 0);

        // Zero input: code equals offset, two clocks of latency
        drive(1, 0);
        chk("lat_1clk_ov", out_valid, 0);
        drive(0, 0);
        chk("lat_2clk_ov", out_valid, 1);
        chk("zero_dac", dac_out, 8192);
        chk("zero_sat", sat_flag, 0);
        drive(0, 0);
        chk("lat_3clk_ov", out_valid, 0);

        rv[0] = 6553600; rv[1] = 32768; rv[2] = -32768; rv[3] = -32769;
        for (int i = 0; i < 4; i++) begin
            drive(1, rv[i]);
            drive(0, 0);
            chk($sformatf("round_%0d", i), dac_out, (i == 0) ? 8292 : (i == 1) ? 8193 : (i == 2) ? 8192 : 8191);
        end

        drive(1, 9000 * 65536);
        drive(0, 0);
        chk("sat_hi_dac", dac_out, 16383);
        chk("sat_hi_flag", sat_flag, 1);
        drive(1, -9000 * 65536);
        drive(0, 0);
        chk("sat_lo_dac", dac_out, 0);
        chk("sat_lo_flag", sat_flag, 1);
`ifdef DAC_SAT_COUNTER_EN
        chk("sat_count_2", sat_count, 2);
        sat_clr = 1;
        drive(1, 9000 * 65536);
        drive(0, 0);
        sat_clr = 0;
        chk("sat_clr_prec", sat_count, 0);
        chk("sat_clr_flag", sat_flag, 1);
`endif

        // Peak window with a gap after the second sample
        pulse_reset();
        drive(1, 8 * 65536);
        drive(1, 108 * 65536);
        drive(0, 0);
        drive(1, 58 * 65536);
        drive(1, -92 * 65536);
        drive(0, 0);
        chk("win1_4th_ov", out_valid, 1);
        chk("win1_4th_dac", dac_out, 8100);
        chk("win1_pv_early", peak_valid, 0);
        drive(0, 0);
        chk("win1_pv", peak_valid, 1);
        chk("win1_peak", peak, 8300);
        drive(0, 0);
        chk("win1_pv_drop", peak_valid, 0);
        chk("win1_peak_hold", peak, 8300);
        for (int i = 0; i < 4; i++) drive(1, 0);
        drive(0, 0);
        drive(0, 0);
        chk("win2_pv", peak_valid, 1);
        chk("win2_peak", peak, 8192);

        // Reset after two samples of a window, with a third in flight
        drive(1, 200 * 65536);
        drive(1, 201 * 65536);
        drive(0, 0);
        drive(1, 202 * 65536);
        pulse_reset();
        drive(1, 18 * 65536);
        chk("post_rst_1clk", out_valid, 0);
        drive(1, 28 * 65536);
        chk("post_rst_2clk", out_valid, 1);
        chk("post_rst_dac", dac_out, 8210);
        drive(1, 38 * 65536);
        drive(0, 0);
        drive(0, 0);
        chk("post_rst_no_pv", peak_valid, 0);
        drive(1, 13 * 65536);
        drive(0, 0);
        drive(0, 0);
        chk("post_rst_pv", peak_valid, 1);
        chk("post_rst_peak", peak, 8230);

        // Bubble pattern 1,0,1,1,0 reappears two clocks later
        bp = '{1, 0, 1, 1, 0};
        bv = '{1 * 65536, 2 * 65536, 3 * 65536, 4 * 65536, 5 * 65536};
        drive(0, 0);
        for (int j = 0; j < 7; j++) begin
            if (j < 5) drive(bp[j], bv[j]);
            else drive(0, 0);
            obs[j] = out_valid;
            if (j == 2) chk("bubble_hold_a", dac_out, 8193);
            if (j == 5) chk("bubble_hold_b", dac_out, 8196);
        end
        chk("bubble_ov0", obs[0], 0);
        for (int j = 1; j < 7; j++)
            chk($sformatf("bubble_ov%0d", j), obs[j], (j <= 5) ? bp[j-1] : 0);

        // Randomized traffic, mostly near the code range with some full-width values
        for (int n = 0; n < 600; n++) begin
            longint x;
            case ($urandom_range(0, 3))
                0: x = longint'($signed({$urandom, $urandom})) >>> (64 - BITS_IN);
                1: x = longint'($signed($urandom_range(0, 40000))) - 20000;
                default: x = (longint'($signed($urandom_range(0, 20000))) - 10000) * 65536
                             + longint'($urandom_range(0, 65535)) - 32768;
            endcase
`ifdef DAC_SAT_COUNTER_EN
            sat_clr = ($urandom_range(0, 15) == 0);
`endif
            drive($urandom_range(0, 3) != 0, x);
        end
`ifdef DAC_SAT_COUNTER_EN
        sat_clr = 0;
`endif
        drive(0, 0);
        drive(0, 0);
        drive(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dac_conditioner.md
DAC_CONDITIONER -- requirements
Module: dac_conditioner

Interface
Parameters:
- REQ-001 The block SHALL have parameter BITS_IN, default 50: width of the signed filtered input sample, equal to the IIR output width.
- REQ-002 The block SHALL have parameter BITS_OUT, default 14: DAC code width (unsigned, offset binary).
- REQ-003 The block SHALL have parameter SHIFT, default 16: arithmetic right shift (gain 2^-SHIFT) applied to the input, 1 <= SHIFT < BITS_IN.
- REQ-004 The block SHALL have parameter OFFSET, default 8192: baseline code added after scaling, 0 <= OFFSET < 2^BITS_OUT.
- REQ-005 The block SHALL have parameter WINDOW, default 1024: valid samples per peak-hold window, WINDOW >= 2.

Ports:
- REQ-006 The block SHALL have a port clock, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-007 The block SHALL have a port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-008 The block SHALL have a port in_valid, input, 1 bit: the input sample is valid this cycle.
- REQ-009 The block SHALL have a port in, input, BITS_IN bits: the signed filtered sample.
- REQ-010 The block SHALL have a port dac_out, output, BITS_OUT bits: the registered DAC code.
- REQ-011 The block SHALL have a port out_valid, output, 1 bit: dac_out updated this cycle.
- REQ-012 The block SHALL have a port sat_flag, output, 1 bit: the current dac_out was clipped, high or low.
- REQ-013 The block SHALL have a port peak, output, BITS_OUT bits: the maximum dac_out over the last completed window.
- REQ-014 The block SHALL have a port peak_valid, output, 1 bit: one-cycle pulse when peak updates.

Function
- REQ-015 Stage 1 SHALL register s1 = (in + 2^(SHIFT-1)) >>> SHIFT, signed and computed at BITS_IN+1 bits so the rounding add cannot overflow, together with v1 = in_valid.
- REQ-016 Stage 2 SHALL compute t = s1 + OFFSET in full width, and on v1=1 SHALL register dac_out = clip(t, 0, 2^BITS_OUT-1), sat_flag = (t<0 or t>2^BITS_OUT-1), out_valid = 1.
- REQ-017 Latency SHALL be exactly 2 clocks from a valid in sample to out_valid.
- REQ-018 When v1=0, out_valid SHALL be 0 while dac_out and sat_flag hold their previous values; bubbles SHALL propagate without reordering, and back-to-back valid samples SHALL give full throughput.
- REQ-019 The peak tracker SHALL count out_valid samples 0..WINDOW-1 and keep a running maximum of dac_out.
- REQ-020 On the sample where the count reaches WINDOW-1, peak SHALL load max(running, that sample) on the next edge, peak_valid SHALL pulse for 1 cycle, the count SHALL wrap to 0, and the running maximum SHALL restart from the next sample (no sample lost or double-counted).
- REQ-021 Between windows, peak SHALL hold its value; gaps in out_valid SHALL not advance the count.

Reset
- REQ-022 While reset_n=0, the block SHALL asynchronously force dac_out=OFFSET, out_valid=0, sat_flag=0, peak=0, peak_valid=0, v1=0, s1=0, window count=0, running max=0, and sat_count=0 when present.
- REQ-023 A reset mid-window SHALL discard the partial window; samples in flight SHALL be dropped, and the first valid sample after release SHALL appear 2 clocks later.

Configuration
- REQ-024 With macro DAC_SAT_COUNTER_EN defined, the block SHALL add input sat_clr (1 bit) and output sat_count (16 bits), which counts clipped out_valid samples and saturates at 65535.
- REQ-025 When DAC_SAT_COUNTER_EN is defined, sat_clr=1 SHALL zero sat_count on the next edge, taking precedence over a simultaneous increment.
- REQ-026 Without DAC_SAT_COUNTER_EN, the sat_clr and sat_count ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults, WINDOW=4 where noted)
- REQ-027 The bench SHALL check: in=0 with in_valid=1 -> dac_out=8192, sat_flag=0, out_valid exactly 2 clocks later.
- REQ-028 The bench SHALL check rounding: in=6553600 -> 8292; in=32768 -> 8193; in=-32768 -> 8192; in=-32769 -> 8191.
- REQ-029 The bench SHALL check saturation: in=9000*65536 -> 16383 with sat_flag=1; in=-9000*65536 -> 0 with sat_flag=1; with DAC_SAT_COUNTER_EN, sat_count=2; then sat_clr=1 together with a clipped sample -> sat_count=0.
- REQ-030 The bench SHALL check the peak window: WINDOW=4, codes 8200, 8300, 8250, 8100 with an in_valid gap after the 2nd -> peak=8300, peak_valid for 1 cycle after the 4th out_valid; the next window 8192 x4 -> peak=8192.
- REQ-031 The bench SHALL check mid-operation reset: reset_n pulsed low after 2 samples of a window -> outputs at reset values immediately; the next window needs 4 fresh samples before peak_valid.
- REQ-032 The bench SHALL check a bubble pattern: in_valid toggling 1,0,1,1,0 -> out_valid reproduces the same pattern delayed 2 clocks, and dac_out holds during the 0s.
